// File: rtl/ps2_recv.sv
`default_nettype none
// ============================================================================
// Module      : ps2_recv
// Description : PS/2 device-to-host receiver with input synchronisation,
//               glitch filtering, frame checking and E0/F0 prefix decoding.
// Revision    : 1.0 - initial release
// ============================================================================
module ps2_recv #(
  parameter int FILTER  = 8,
  parameter int TIMEOUT = 8192
) (
  input  logic       clk_25mhz,
  input  logic       reset,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] code,
  output logic       extended,
  output logic       released,
  output logic       valid,
  output logic       err
);

  localparam int             CW          = $clog2(FILTER + 1);
  localparam logic [CW-1:0]  c_FILT_LAST = CW'(FILTER - 1);
  localparam int             TW          = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0]  c_TMO       = TW'(TIMEOUT);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_DATA   = 2'd1,
    S_PARITY = 2'd2,
    S_STOP   = 2'd3
  } state_t;

  logic [1:0] w_raw;
  logic [1:0] w_filt;

  assign w_raw = {ps2_clk, ps2_data};

  // Index 1 is the clock line, index 0 the data line; both idle high.
  for (genvar i = 0; i < 2; i++) begin : g_filt
    logic          r_s1;
    logic          r_s2;
    logic          r_filt;
    logic [CW-1:0] r_cnt;

    always_ff @(posedge clk_25mhz or posedge reset) begin
      if (reset) begin
        r_s1   <= 1'b1;
        r_s2   <= 1'b1;
        r_filt <= 1'b1;
        r_cnt  <= '0;
      end else begin
        r_s1 <= w_raw[i];
        r_s2 <= r_s1;
        if (r_s2 != r_filt) begin
          if (r_cnt == c_FILT_LAST) begin
            r_filt <= r_s2;
            r_cnt  <= '0;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end else begin
          r_cnt <= '0;
        end
      end
    end

    assign w_filt[i] = r_filt;
  end

  logic          r_clk_prev;
  logic          w_fall;
  logic          w_dat;
  state_t        r_state;
  state_t        w_state_nx;
  logic [2:0]    r_idx;
  logic [7:0]    r_shift;
  logic          r_par;
  logic          r_par_ok;
  logic [TW-1:0] r_tmo;
  logic          r_ext_pend;
  logic          r_rel_pend;
  logic          w_timeout;
  logic          w_frame_ok;
  logic          w_frame_err;

  assign w_fall    = r_clk_prev & ~w_filt[1];
  assign w_dat     = w_filt[0];
  assign w_timeout = (r_state != S_IDLE) && (r_tmo == c_TMO);

  always_ff @(posedge clk_25mhz or posedge reset) begin
    if (reset) begin
      r_clk_prev <= 1'b1;
      r_state    <= S_IDLE;
    end else begin
      r_clk_prev <= w_filt[1];
      r_state    <= w_state_nx;
    end
  end

  // Timeout wins over a coincident edge so valid and err stay exclusive.
  always_comb begin
    w_state_nx  = r_state;
    w_frame_ok  = 1'b0;
    w_frame_err = 1'b0;
    if (w_timeout) begin
      w_state_nx  = S_IDLE;
      w_frame_err = 1'b1;
    end else if (w_fall) begin
      case (r_state)
        S_IDLE:   if (!w_dat) w_state_nx = S_DATA;
        S_DATA:   if (r_idx == 3'd7) w_state_nx = S_PARITY;
        S_PARITY: w_state_nx = S_STOP;
        S_STOP: begin
          w_state_nx = S_IDLE;
          if (w_dat && r_par_ok) w_frame_ok  = 1'b1;
          else                   w_frame_err = 1'b1;
        end
        default:  w_state_nx = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_25mhz or posedge reset) begin
    if (reset) begin
      r_idx    <= '0;
      r_shift  <= '0;
      r_par    <= 1'b0;
      r_par_ok <= 1'b0;
      r_tmo    <= '0;
    end else begin
      if (w_fall) begin
        r_tmo <= '0;
      end else if ((r_state != S_IDLE) && (r_tmo != c_TMO)) begin
        r_tmo <= r_tmo + 1'b1;
      end
      if (w_fall && !w_timeout) begin
        case (r_state)
          S_IDLE: begin
            r_idx <= '0;
            r_par <= 1'b0;
          end
          S_DATA: begin
            r_shift[r_idx] <= w_dat;
            r_par          <= r_par ^ w_dat;
            r_idx          <= r_idx + 1'b1;
          end
          S_PARITY: r_par_ok <= r_par ^ w_dat;
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk_25mhz or posedge reset) begin
    if (reset) begin
      code       <= 8'h00;
      extended   <= 1'b0;
      released   <= 1'b0;
      valid      <= 1'b0;
      err        <= 1'b0;
      r_ext_pend <= 1'b0;
      r_rel_pend <= 1'b0;
    end else begin
      valid <= 1'b0;
      err   <= 1'b0;
      if (w_frame_err) begin
        err        <= 1'b1;
        r_ext_pend <= 1'b0;
        r_rel_pend <= 1'b0;
      end else if (w_frame_ok) begin
        if (r_shift == 8'hE0) begin
          r_ext_pend <= 1'b1;
        end else if (r_shift == 8'hF0) begin
          r_rel_pend <= 1'b1;
        end else begin
          code       <= r_shift;
          extended   <= r_ext_pend;
          released   <= r_rel_pend;
          valid      <= 1'b1;
          r_ext_pend <= 1'b0;
          r_rel_pend <= 1'b0;
        end
      end
    end
  end

endmodule
`default_nettype wire
